array_port_mux: RTL and testbench

//  Arbitrates PORT_NUM HLS array ports onto BANK_NUM array-cache banks and sits directly upstream of the

---
 rtl/array_port_mux_pkg.sv | 32 +++
 rtl/array_port_mux_if.sv | 39 +++
 rtl/array_tag_fifo.sv | 53 +++++
 rtl/array_port_mux.sv | 156 +++++++++++++++
 tb/tb_array_port_mux.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/array_port_mux_pkg.sv
// Shared parameters and request type for the array-port-to-bank multiplexer.
package array_port_mux_pkg;

    localparam int PORT_NUM           = 4;
    localparam int ARRAY_BANK_NUM     = 4;
    localparam int ARRAY_BANK_BYTE_AW = 8;
    localparam int ARRAY_BANK_DW      = 32;
    localparam int ARRAY_TAG_DEPTH    = 4;

    localparam int BANK_NUM  = ARRAY_BANK_NUM;
    localparam int BANK_AW   = ARRAY_BANK_BYTE_AW;
    localparam int DW        = ARRAY_BANK_DW;
    localparam int TAG_DEPTH = ARRAY_TAG_DEPTH;
    localparam int BANK_SW   = $clog2(BANK_NUM);
    localparam int PORT_AW   = BANK_AW + BANK_SW;
    localparam int PORT_IW   = $clog2(PORT_NUM);
    localparam int CNT_W     = $clog2(BANK_NUM * TAG_DEPTH + 1);

    typedef struct packed {
        logic               re;
        logic               we;
        logic [1:0]         len;
        logic [PORT_AW-1:0] adr;
        logic [DW-1:0]      din;
    } array_req_t;

    // The top address bits select the bank.
    function automatic logic [BANK_SW-1:0] bank_of(input logic [PORT_AW-1:0] adr);
        return adr[PORT_AW-1 -: BANK_SW];
    endfunction

endpackage

// File: rtl/array_port_mux_if.sv
// Requester-port and bank-side bundle of the array port multiplexer.
interface array_port_mux_if;
    import array_port_mux_pkg::*;

    // Handshake: a request (re or we) is held by the requester until port_ready is seen
    // high in the same cycle; bank_re/we are valid and transfer when bank_ready is high.
    logic [PORT_NUM-1:0] port_re;
    logic [PORT_NUM-1:0] port_we;
    logic [1:0]          port_len      [PORT_NUM];
    logic [PORT_AW-1:0]  port_adr      [PORT_NUM];
    logic [DW-1:0]       port_din      [PORT_NUM];
    logic [PORT_NUM-1:0] port_ready;
    logic [DW-1:0]       port_dout     [PORT_NUM];
    logic [PORT_NUM-1:0] port_dout_vld;

    logic [BANK_NUM-1:0] bank_ready;
    logic [BANK_NUM-1:0] bank_re;
    logic [BANK_NUM-1:0] bank_we;
    logic [1:0]          bank_len      [BANK_NUM];
    logic [BANK_AW-1:0]  bank_bankAdr  [BANK_NUM];
    logic [DW-1:0]       bank_din      [BANK_NUM];
    logic [DW-1:0]       bank_dout     [BANK_NUM];
    logic [BANK_NUM-1:0] bank_dout_vld;

    modport slave (
        input  port_re, port_we, port_len, port_adr, port_din,
        output port_ready, port_dout, port_dout_vld,
        input  bank_ready, bank_dout, bank_dout_vld,
        output bank_re, bank_we, bank_len, bank_bankAdr, bank_din
    );

    modport master (
        output port_re, port_we, port_len, port_adr, port_din,
        input  port_ready, port_dout, port_dout_vld,
        output bank_ready, bank_dout, bank_dout_vld,
        input  bank_re, bank_we, bank_len, bank_bankAdr, bank_din
    );

endinterface

// File: rtl/array_tag_fifo.sv
// Per-bank FIFO of requester ids for reads still waiting on their bank return.
module array_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // A push while full is only issued alongside a pop, so the count never overflows.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/array_port_mux.sv
// Round-robin arbitration of HLS array ports onto cache banks, with in-order read return per port.
module array_port_mux
    import array_port_mux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    array_port_mux_if.slave  io,
    output logic             err_orphan
);

    array_req_t          req       [PORT_NUM];
    logic [BANK_SW-1:0]  req_bank  [PORT_NUM];
    logic [PORT_NUM-1:0] rd_req;
    logic [PORT_NUM-1:0] wr_req;

    logic [PORT_NUM-1:0] elig      [BANK_NUM];
    logic [BANK_NUM-1:0] gnt_vld;
    logic [PORT_IW-1:0]  gnt_id    [BANK_NUM];
    logic [BANK_NUM-1:0] accept;

    logic [BANK_NUM-1:0] fifo_push;
    logic [BANK_NUM-1:0] fifo_pop;
    logic [BANK_NUM-1:0] fifo_full;
    logic [BANK_NUM-1:0] fifo_empty;
    logic [PORT_IW-1:0]  fifo_head [BANK_NUM];

    logic [PORT_IW-1:0]  rr_ptr    [BANK_NUM];
    logic [CNT_W-1:0]    outst     [PORT_NUM];
    logic [BANK_SW-1:0]  last_bank [PORT_NUM];

    logic [PORT_NUM-1:0] acc_rd;
    logic [BANK_SW-1:0]  acc_bank  [PORT_NUM];
    logic [PORT_NUM-1:0] ret_hit;
    logic [DW-1:0]       ret_data  [PORT_NUM];
    logic [PORT_NUM-1:0] dout_vld_q;
    logic [DW-1:0]       dout_q    [PORT_NUM];

    // A write on the same port masks a read request.
    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            req[p]      = '{re: io.port_re[p], we: io.port_we[p], len: io.port_len[p],
                            adr: io.port_adr[p], din: io.port_din[p]};
            req_bank[p] = bank_of(req[p].adr);
            wr_req[p]   = req[p].we;
            rd_req[p]   = req[p].re & ~req[p].we;
        end
    end

    // Reads stay on one bank while a port has returns pending, which keeps per-port return order.
    always_comb begin
        for (int b = 0; b < BANK_NUM; b++) begin
            fifo_pop[b] = io.bank_dout_vld[b] & ~fifo_empty[b];
            for (int p = 0; p < PORT_NUM; p++) begin
                elig[b][p] = (req_bank[p] == BANK_SW'(b)) &&
                             (wr_req[p] ||
                              (rd_req[p] && (!fifo_full[b] || fifo_pop[b]) &&
                               (outst[p] == '0 || last_bank[p] == BANK_SW'(b))));
            end
        end
    end

    always_comb begin
        for (int b = 0; b < BANK_NUM; b++) begin
            gnt_vld[b] = 1'b0;
            gnt_id[b]  = '0;
            for (int k = 0; k < PORT_NUM; k++) begin
                if (!gnt_vld[b] && elig[b][(int'(rr_ptr[b]) + k) % PORT_NUM]) begin
                    gnt_vld[b] = 1'b1;
                    gnt_id[b]  = PORT_IW'((int'(rr_ptr[b]) + k) % PORT_NUM);
                end
            end
        end
    end

    always_comb begin
        for (int b = 0; b < BANK_NUM; b++) begin
            accept[b]          = gnt_vld[b] & io.bank_ready[b] & ~rst;
            fifo_push[b]       = accept[b] & rd_req[gnt_id[b]];
            io.bank_re[b]      = gnt_vld[b] & rd_req[gnt_id[b]] & ~rst;
            io.bank_we[b]      = gnt_vld[b] & wr_req[gnt_id[b]] & ~rst;
            io.bank_len[b]     = req[gnt_id[b]].len;
            io.bank_bankAdr[b] = req[gnt_id[b]].adr[BANK_AW-1:0];
            io.bank_din[b]     = req[gnt_id[b]].din;
        end
    end

    always_comb begin
        io.port_ready = '0;
        acc_rd        = '0;
        ret_hit       = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            acc_bank[p] = '0;
            ret_data[p] = '0;
        end
        for (int b = 0; b < BANK_NUM; b++) begin
            if (accept[b]) begin
                io.port_ready[gnt_id[b]] = 1'b1;
                if (rd_req[gnt_id[b]]) begin
                    acc_rd[gnt_id[b]]   = 1'b1;
                    acc_bank[gnt_id[b]] = BANK_SW'(b);
                end
            end
            if (fifo_pop[b]) begin
                ret_hit[fifo_head[b]]  = 1'b1;
                ret_data[fifo_head[b]] = io.bank_dout[b];
            end
        end
    end

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_tag
        array_tag_fifo #(.DEPTH(TAG_DEPTH), .W(PORT_IW)) u_tag_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (fifo_push[b]),
            .push_data (gnt_id[b]),
            .pop       (fifo_pop[b]),
            .head      (fifo_head[b]),
            .full      (fifo_full[b]),
            .empty     (fifo_empty[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < BANK_NUM; b++) rr_ptr[b] <= '0;
            for (int p = 0; p < PORT_NUM; p++) begin
                outst[p]     <= '0;
                last_bank[p] <= '0;
                dout_q[p]    <= '0;
            end
            dout_vld_q <= '0;
            err_orphan <= 1'b0;
        end else begin
            for (int b = 0; b < BANK_NUM; b++) begin
                if (accept[b]) rr_ptr[b] <= PORT_IW'((int'(gnt_id[b]) + 1) % PORT_NUM);
            end
            for (int p = 0; p < PORT_NUM; p++) begin
                case ({acc_rd[p], ret_hit[p]})
                    2'b10:   outst[p] <= outst[p] + 1'b1;
                    2'b01:   outst[p] <= outst[p] - 1'b1;
                    default: outst[p] <= outst[p];
                endcase
                if (acc_rd[p])  last_bank[p] <= acc_bank[p];
                if (ret_hit[p]) dout_q[p]    <= ret_data[p];
            end
            dout_vld_q <= ret_hit;
            if (|(io.bank_dout_vld & fifo_empty)) err_orphan <= 1'b1;
        end
    end

    always_comb begin
        io.port_dout_vld = dout_vld_q;
        for (int p = 0; p < PORT_NUM; p++) io.port_dout[p] = dout_q[p];
    end

endmodule

// File: tb/tb_array_port_mux.sv
// Bench for array_port_mux: scenario tasks plus a bank model and per-port return scoreboard.
module tb_array_port_mux;
  import array_port_mux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic err_orphan;

  array_port_mux_if bus();

  array_port_mux dut (
    .clk        (clk),
    .rst        (rst),
    .io         (bus),
    .err_orphan (err_orphan)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q  [PORT_NUM][$];
  logic [DW-1:0] pend_q [BANK_NUM][$];
  int acc_log[$];
  int ret_log[$];
  logic [BANK_NUM-1:0] auto_ret;
  int rel_req  [BANK_NUM];
  int rel_done [BANK_NUM];
  int orph_req [BANK_NUM];
  int orph_done[BANK_NUM];

  function automatic logic [DW-1:0] data_of(input int b, input logic [BANK_AW-1:0] a);
    return DW'(b * 65536) + DW'(a);
  endfunction

  // Banks answer one cycle after acceptance; controls are changed only at negedge+4.
  task automatic bank_model();
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      for (int b = 0; b < BANK_NUM; b++) begin
        bus.bank_dout_vld[b] = 1'b0;
        bus.bank_dout[b] = '0;
        if (pend_q[b].size() > 0 && (auto_ret[b] || rel_req[b] != rel_done[b])) begin
          bus.bank_dout_vld[b] = 1'b1;
          bus.bank_dout[b] = pend_q[b].pop_front();
          if (!auto_ret[b]) rel_done[b]++;
        end else if (orph_req[b] != orph_done[b]) begin
          bus.bank_dout_vld[b] = 1'b1;
          bus.bank_dout[b] = 32'hDEAD_0000 + DW'(b);
          orph_done[b]++;
        end
      end
      #3;
      for (int b = 0; b < BANK_NUM; b++)
        if (bus.bank_re[b] && bus.bank_ready[b])
          pend_q[b].push_back(data_of(b, bus.bank_bankAdr[b]));
      for (int p = 0; p < PORT_NUM; p++) begin
        if (bus.port_ready[p]) begin
          acc_log.push_back(p);
          if (bus.port_re[p] && !bus.port_we[p])
            exp_q[p].push_back(data_of(int'(bank_of(bus.port_adr[p])), bus.port_adr[p][BANK_AW-1:0]));
        end
        if (bus.port_dout_vld[p]) begin
          ret_log.push_back(p);
          n_tests++;
          if (exp_q[p].size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected port%0d: got %h, required no return", p, bus.port_dout[p]);
          end else begin
            e = exp_q[p].pop_front();
            if (bus.port_dout[p] !== e) begin
              n_fail++;
              $display("FAIL sb_data port%0d: got %h, required %h", p, bus.port_dout[p], e);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int p = 0; p < PORT_NUM; p++) bus.port_adr[p] = {2'b00, 8'(p)};
    bus.port_re = '1;
    repeat (2) @(negedge clk);
    #4;
    n_tests++;
    if (bus.bank_re !== '0 || bus.bank_we !== '0) begin
      n_fail++; $display("FAIL rst_bank: got re=%b we=%b, required 0", bus.bank_re, bus.bank_we);
    end
    n_tests++;
    if (bus.port_ready !== '0) begin
      n_fail++; $display("FAIL rst_ready: got %b, required 0", bus.port_ready);
    end
    n_tests++;
    if (bus.port_dout_vld !== '0 || err_orphan !== 1'b0) begin
      n_fail++; $display("FAIL rst_vld: got vld=%b err=%b, required 0", bus.port_dout_vld, err_orphan);
    end
    for (int p = 0; p < PORT_NUM; p++) begin
      n_tests++;
      if (bus.port_dout[p] !== '0) begin
        n_fail++; $display("FAIL rst_dout port%0d: got %h, required 0", p, bus.port_dout[p]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #4;
    n_tests++;
    if (bus.port_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rst_first_grant: got %b, required 0001", bus.port_ready);
    end
    @(negedge clk);
    bus.port_re = '0;
  endtask

  task automatic test_contention();
    int order [5] = '{0, 1, 2, 3, 0};
    repeat (4) @(negedge clk);
    ret_log.delete();
    for (int p = 0; p < PORT_NUM; p++) bus.port_adr[p] = {2'b01, 8'(16 * p)};
    bus.port_re = '1;
    for (int i = 0; i < 5; i++) begin
      #4;
      n_tests++;
      if (bus.port_ready !== 4'(1 << order[i])) begin
        n_fail++; $display("FAIL rr_grant cycle%0d: got %b, required port %0d", i, bus.port_ready, order[i]);
      end
      @(negedge clk);
    end
    bus.port_re = '0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (ret_log.size() != 5) begin
      n_fail++; $display("FAIL rr_ret_count: got %0d, required 5", ret_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (ret_log[i] != order[i]) begin
          n_fail++; $display("FAIL rr_ret_order %0d: got port %0d, required %0d", i, ret_log[i], order[i]);
        end
      end
    end
  endtask

  task automatic test_tag_full();
    repeat (3) @(negedge clk);
    #4;
    auto_ret[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.port_adr[0] = {2'b10, 8'(32 + i)};
      bus.port_re[0] = 1'b1;
      #4;
      n_tests++;
      if (bus.port_ready !== 4'b0001) begin
        n_fail++; $display("FAIL tag_accept %0d: got %b, required 0001", i, bus.port_ready);
      end
    end
    @(negedge clk);
    bus.port_adr[0] = {2'b10, 8'd36};
    for (int i = 0; i < 2; i++) begin
      #4;
      n_tests++;
      if (bus.port_ready !== 4'b0000) begin
        n_fail++; $display("FAIL tag_full_stall %0d: got %b, required 0000", i, bus.port_ready);
      end
      if (i == 1) rel_req[2]++;
      @(negedge clk);
    end
    #4;
    n_tests++;
    if (bus.port_ready !== 4'b0001) begin
      n_fail++; $display("FAIL tag_pop_push: got %b, required 0001", bus.port_ready);
    end
    @(negedge clk);
    bus.port_re[0] = 1'b0;
    #4;
    auto_ret[2] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_ordering();
    #4;
    auto_ret[0] = 1'b0;
    @(negedge clk);
    bus.port_adr[0] = {2'b00, 8'h11};
    bus.port_re[0] = 1'b1;
    #4;
    n_tests++;
    if (bus.port_ready !== 4'b0001) begin
      n_fail++; $display("FAIL ord_first: got %b, required 0001", bus.port_ready);
    end
    @(negedge clk);
    bus.port_adr[0] = {2'b01, 8'h05};
    for (int i = 0; i < 3; i++) begin
      #4;
      n_tests++;
      if (bus.port_ready !== 4'b0000 || bus.bank_re[1] !== 1'b0 || bus.port_dout_vld[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL ord_hold %0d: got ready=%b bank_re1=%b vld0=%b, required 0,0,0",
                 i, bus.port_ready, bus.bank_re[1], bus.port_dout_vld[0]);
      end
      if (i == 1) rel_req[0]++;
      @(negedge clk);
    end
    #4;
    n_tests++;
    if (bus.port_dout_vld[0] !== 1'b1 || bus.port_dout[0] !== 32'h11) begin
      n_fail++; $display("FAIL ord_return: got vld=%b data=%h, required 1 and 00000011",
                         bus.port_dout_vld[0], bus.port_dout[0]);
    end
    n_tests++;
    if (bus.port_ready !== 4'b0001 || bus.bank_re[1] !== 1'b1) begin
      n_fail++; $display("FAIL ord_issue: got ready=%b bank_re1=%b, required 0001 and 1",
                         bus.port_ready, bus.bank_re[1]);
    end
    @(negedge clk);
    bus.port_re[0] = 1'b0;
    #4;
    auto_ret[0] = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_priority();
    int ret_before;
    ret_before = ret_log.size();
    bus.bank_ready[3] = 1'b0;
    bus.port_adr[3] = {2'b11, 8'h10};
    bus.port_din[3] = 32'hA5;
    bus.port_len[3] = 2'd0;
    bus.port_re[3] = 1'b1;
    bus.port_we[3] = 1'b1;
    #4;
    n_tests++;
    if (bus.bank_we[3] !== 1'b1 || bus.bank_re[3] !== 1'b0 || bus.port_ready !== 4'b0000) begin
      n_fail++; $display("FAIL wp_wait: got we=%b re=%b ready=%b, required 1,0,0000",
                         bus.bank_we[3], bus.bank_re[3], bus.port_ready);
    end
    @(negedge clk);
    bus.bank_ready[3] = 1'b1;
    #4;
    n_tests++;
    if (bus.port_ready !== 4'b1000 || bus.bank_we[3] !== 1'b1 || bus.bank_re[3] !== 1'b0) begin
      n_fail++; $display("FAIL wp_accept: got ready=%b we=%b re=%b, required 1000,1,0",
                         bus.port_ready, bus.bank_we[3], bus.bank_re[3]);
    end
    n_tests++;
    if (bus.bank_bankAdr[3] !== 8'h10 || bus.bank_din[3] !== 32'hA5 || bus.bank_len[3] !== 2'd0) begin
      n_fail++; $display("FAIL wp_bus: got adr=%h din=%h len=%0d, required 10 a5 0",
                         bus.bank_bankAdr[3], bus.bank_din[3], bus.bank_len[3]);
    end
    @(negedge clk);
    bus.port_re[3] = 1'b0;
    bus.port_we[3] = 1'b0;
    bus.port_len[3] = 2'd3;
    repeat (4) @(negedge clk);
    n_tests++;
    if (ret_log.size() != ret_before) begin
      n_fail++; $display("FAIL wp_no_return: got %0d returns, required 0", ret_log.size() - ret_before);
    end
  endtask

  task automatic test_random();
    int acc_before;
    acc_before = acc_log.size();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int p = 0; p < PORT_NUM; p++) begin
        bus.port_re[p]  = ($urandom_range(0, 3) != 0);
        bus.port_we[p]  = ($urandom_range(0, 5) == 0);
        bus.port_adr[p] = PORT_AW'($urandom_range(0, (1 << PORT_AW) - 1));
        bus.port_din[p] = $urandom;
        bus.port_len[p] = ($urandom_range(0, 1) == 0) ? 2'd3 : 2'd1;
      end
      for (int b = 0; b < BANK_NUM; b++) bus.bank_ready[b] = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    bus.port_re = '0;
    bus.port_we = '0;
    bus.bank_ready = '1;
    repeat (10) @(negedge clk);
    n_tests++;
    if (acc_log.size() - acc_before < 100) begin
      n_fail++; $display("FAIL rand_activity: got %0d accepts, required at least 100", acc_log.size() - acc_before);
    end
  endtask

  task automatic test_orphan();
    repeat (2) @(negedge clk);
    #4;
    n_tests++;
    if (err_orphan !== 1'b0) begin
      n_fail++; $display("FAIL orph_pre: got %b, required 0", err_orphan);
    end
    orph_req[1]++;
    repeat (2) @(negedge clk);
    #4;
    n_tests++;
    if (err_orphan !== 1'b1 || bus.port_dout_vld !== '0) begin
      n_fail++; $display("FAIL orph_flag: got err=%b vld=%b, required 1 and 0000", err_orphan, bus.port_dout_vld);
    end
    repeat (3) @(negedge clk);
    #4;
    n_tests++;
    if (err_orphan !== 1'b1) begin
      n_fail++; $display("FAIL orph_sticky: got %b, required 1", err_orphan);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #4;
    n_tests++;
    if (err_orphan !== 1'b0) begin
      n_fail++; $display("FAIL orph_clear: got %b, required 0", err_orphan);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.port_re = '0;
    bus.port_we = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      bus.port_len[p] = 2'd3;
      bus.port_adr[p] = '0;
      bus.port_din[p] = '0;
    end
    bus.bank_ready = '1;
    bus.bank_dout_vld = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      bus.bank_dout[b] = '0;
      rel_req[b] = 0;
      rel_done[b] = 0;
      orph_req[b] = 0;
      orph_done[b] = 0;
    end
    auto_ret = '1;
    fork
      bank_model();
    join_none

    test_reset();
    test_contention();
    test_tag_full();
    test_ordering();
    test_write_priority();
    test_random();
    test_orphan();

    for (int p = 0; p < PORT_NUM; p++) begin
      n_tests++;
      if (exp_q[p].size() != 0) begin
        n_fail++; $display("FAIL sb_drain port%0d: got %0d reads without return, required 0", p, exp_q[p].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
